// File: rtl/aes_subword_issuer_pkg.sv
// Shared AES definitions for the SubWord issuer: FSM encoding and word width.
package aes_subword_issuer_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } issuer_state_e;

endpackage

// File: rtl/aes_subword_issuer.sv
// Walks a 1..4 word block through an external SubBytes unit one word at a time,
// writing each result back in place, then presents the whole block.
module aes_subword_issuer
    import aes_subword_issuer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     g_clk,
    input  logic                     g_reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_dec,
    input  logic [WORD_W*WORDS-1:0]  req_state,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WORD_W*WORDS-1:0]  rsp_state,
    output logic                     sb_valid,
    output logic                     sb_dec,
    output logic [WORD_W-1:0]        sb_rs1,
    input  logic                     sb_ready,
    input  logic [WORD_W-1:0]        sb_rd
);

    issuer_state_e                   state;
    logic [1:0]                      idx;
    logic [WORDS-1:0][WORD_W-1:0]    wbuf;
    logic                            last;

    assign last = (idx == 2'(WORDS - 1));

    // All outputs are registered; sb_dec doubles as the captured direction.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state     <= IDLE;
            idx       <= 2'd0;
            wbuf      <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_state <= '0;
            sb_valid  <= 1'b0;
            sb_dec    <= 1'b0;
            sb_rs1    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wbuf      <= req_state;
                        sb_dec    <= req_dec;
                        idx       <= 2'd0;
                        req_ready <= 1'b0;
                        sb_valid  <= 1'b1;
                        sb_rs1    <= req_state[WORD_W-1:0];
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sb_ready) begin
                        wbuf[idx] <= sb_rd;
                        if (last) begin
                            sb_valid  <= 1'b0;
                            sb_rs1    <= '0;
                            rsp_valid <= 1'b1;
                            // wbuf[idx] only lands next cycle, so splice sb_rd in here.
                            for (int i = 0; i < WORDS; i++)
                                rsp_state[WORD_W*i +: WORD_W] <= (idx == 2'(i)) ? sb_rd : wbuf[i];
                            state     <= DONE;
                        end else begin
                            idx    <= idx + 2'd1;
                            sb_rs1 <= wbuf[idx + 2'd1];
                        end
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_state <= '0;
                        req_ready <= 1'b1;
                        sb_dec    <= 1'b0;
                        idx       <= 2'd0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_subword_issuer.sv
// Randomized bench: the bench plays the SubBytes unit and checks the issuer
// against a byte-wise S-box model of the whole block.
module tb_aes_subword_issuer;

    localparam int WORDS = 4;
    localparam int BW    = 32 * WORDS;

    logic            g_clk;
    logic            g_reset;
    logic            req_valid;
    logic            req_ready;
    logic            req_dec;
    logic [BW-1:0]   req_state;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [BW-1:0]   rsp_state;
    logic            sb_valid;
    logic            sb_dec;
    logic [31:0]     sb_rs1;
    logic            sb_ready;
    logic [31:0]     sb_rd;

    aes_subword_issuer #(.WORDS(WORDS)) dut (
        .g_clk     (g_clk),
        .g_reset   (g_reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dec   (req_dec),
        .req_state (req_state),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_state (rsp_state),
        .sb_valid  (sb_valid),
        .sb_dec    (sb_dec),
        .sb_rs1    (sb_rs1),
        .sb_ready  (sb_ready),
        .sb_rd     (sb_rd)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // S-box tables built from GF(2^8) inversion plus the affine map.
    logic [7:0] sbox  [256];
    logic [7:0] isbox [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] d = {x, x};
        return d[15-n -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w, input logic d);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = d ? isbox[w[8*i +: 8]] : sbox[w[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [BW-1:0] sub_block(input logic [BW-1:0] s, input logic d);
        logic [BW-1:0] r;
        for (int i = 0; i < WORDS; i++) r[32*i +: 32] = sub_word(s[32*i +: 32], d);
        return r;
    endfunction

    // Monitor / responder state
    logic          mon_en = 1'b0;
    int            mode = 0;          // 0 zero-wait, 1 random stall, 2 ready on 3rd valid cycle
    logic [BW-1:0] exp_in = '0;
    logic          exp_dec = 1'b0;
    int            k = 0;
    int            n_stall = 0;
    int            wcyc = 0;
    logic          hs_flag = 1'b0;
    logic          stall_prev = 1'b0;
    logic [31:0]   rs1_prev = '0;
    logic          rsp_pend = 1'b0;
    logic [BW-1:0] rsp_prev = '0;

    always @(posedge g_clk) begin
        hs_flag    <= sb_valid && sb_ready;
        stall_prev <= !g_reset && sb_valid && !sb_ready;
        rs1_prev   <= sb_rs1;
        rsp_pend   <= !g_reset && rsp_valid && !rsp_ready;
        rsp_prev   <= rsp_state;
        if (sb_valid && !sb_ready) n_stall <= n_stall + 1;
        if (g_reset || (req_valid && req_ready)) k <= 0;
        else if (sb_valid && sb_ready) k <= k + 1;
    end

    always @(negedge g_clk) begin
        if (mon_en) begin
            if (!sb_valid) chk("rs1_gate", sb_rs1, 0);
            else begin
                chk("sb_dec", sb_dec, exp_dec);
                if (k < WORDS) chk("sb_rs1", sb_rs1, exp_in[32*k +: 32]);
                if (stall_prev) chk("rs1_stable", sb_rs1, rs1_prev);
            end
            if (req_ready) chk("idle_outs", {sb_valid, sb_dec, rsp_valid}, 0);
            if (rsp_pend) chk("rsp_stable", rsp_state, rsp_prev);
        end
        if (!sb_valid) wcyc = 0;
        else if (hs_flag || wcyc == 0) wcyc = 1;
        else wcyc = wcyc + 1;
        case (mode)
            0:       sb_ready = 1'b1;
            1:       sb_ready = ($urandom_range(0, 2) != 0);
            default: sb_ready = sb_valid ? (wcyc == 3) : 1'($urandom_range(0, 1));
        endcase
        sb_rd = sb_valid ? sub_word(sb_rs1, sb_dec) : (32'hdeadbeef ^ $urandom);
    end

    task automatic do_block(input logic [BW-1:0] st, input logic d, input int hold,
                            input int exp_lat, output logic [BW-1:0] got);
        int c;
        int s0;
        logic [BW-1:0] exp;
        got = '0;
        chk("req_ready_idle", req_ready, 1);
        exp_in = st; exp_dec = d; s0 = n_stall;
        req_state = st; req_dec = d; req_valid = 1'b1;
        c = 0;
        do begin
            @(negedge g_clk);
            c++;
            req_valid = 1'($urandom_range(0, 1));
            req_state = {$urandom, $urandom, $urandom, $urandom};
            req_dec   = 1'($urandom_range(0, 1));
        end while (!rsp_valid && c < 200);
        if (!rsp_valid) begin
            chk("rsp_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        if (exp_lat < 0) exp_lat = WORDS + 1 + (n_stall - s0);
        chk("latency", c, exp_lat);
        exp = sub_block(st, d);
        got = rsp_state;
        chk("rsp_state", rsp_state, exp);
        chk("req_ready_busy", req_ready, 0);
        rsp_ready = 1'b0;
        repeat (hold) begin
            req_valid = 1'b1;
            req_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge g_clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_state", rsp_state, exp);
            chk("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge g_clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("rsp_dropped", rsp_valid, 0);
        chk("back_idle", req_ready, 1);
    endtask

    initial begin
        logic [BW-1:0] st;
        logic [BW-1:0] got;

        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
            sbox[x]  = b;
            isbox[b] = 8'(x);
        end

        g_reset = 1'b1; req_valid = 1'b0; req_dec = 1'b0; req_state = '0;
        rsp_ready = 1'b0; sb_ready = 1'b0; sb_rd = '0;
        repeat (3) @(negedge g_clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_sb_valid", sb_valid, 0);
        chk("rst_sb_rs1", sb_rs1, 0);
        chk("rst_sb_dec", sb_dec, 0);
        chk("rst_rsp_state", rsp_state, 0);
        g_reset = 1'b0;
        mon_en  = 1'b1;

        mode = 0;
        do_block('0, 1'b0, 0, 5, got);
        chk("enc_zero", got, {16{8'h63}});
        do_block({16{8'h63}}, 1'b1, 0, 5, got);
        chk("dec_63", got, 0);
        do_block({96'h0, 32'h00010253}, 1'b0, 0, 5, got);
        chk("byte_order", got, {{3{32'h63636363}}, 32'h637c77ed});

        mode = 2;
        do_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 0, 13, got);
        mode = 0;
        do_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, 5, -1, got);

        // Reset pulsed while the third word is in flight.
        st = {$urandom, $urandom, $urandom, $urandom};
        exp_in = st; exp_dec = 1'b1;
        req_state = st; req_dec = 1'b1; req_valid = 1'b1;
        @(negedge g_clk);
        req_valid = 1'b0;
        repeat (2) @(negedge g_clk);
        chk("pre_rst_valid", sb_valid, 1);
        chk("pre_rst_rs1", sb_rs1, st[64 +: 32]);
        g_reset = 1'b1;
        @(negedge g_clk);
        g_reset = 1'b0;
        chk("mid_rst_sb_valid", sb_valid, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_sb_dec", sb_dec, 0);
        chk("mid_rst_rsp_state", rsp_state, 0);
        do_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1, -1, got);

        for (int n = 0; n < 12; n++) begin
            mode = $urandom_range(0, 2);
            do_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), -1, got);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
